ram_bus_slave: RTL and testbench
================================

Name: ram_bus_slave

Overview:
- Bus responder (slave) side of the burst bus that ramDmaCi masters.
- Decodes a word-addressed window, accepts write bursts into an on-chip byte-writable RAM, and answers read bursts.
- Gives the DMA controller a self-contained bus target for integration and regression.
- Drives its bus outputs only while responding; otherwise they are zero, so they can be OR-combined on the shared bus.

Parameters:
- BASE_ADDR, 32'h0000_4000, byte address of word 0 of the window.
- ADDR_BITS, 10, log2 of the word depth; DEPTH = 2^ADDR_BITS words.
- BUSY_EVERY, 0, insert one busy cycle after every Nth accepted write word; 0 = never busy.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- beginTransactionIn  in  1  one-cycle start strobe from master.
- endTransactionIn  in  1  master end/abort of write burst (also abort of read).
- readNotWriteIn  in  1  1 = read, sampled with beginTransactionIn.
- dataValidIn  in  1  master write word valid.
- addressDataIn  in  32  address at begin, write data afterwards.
- byteEnablesIn  in  4  byte lane enables, sampled with every write word.
- burstSizeIn  in  8  words−1, sampled with beginTransactionIn.
- addressDataOut  out  32  read data; zero when not valid.
- dataValidOut  out  1  read word valid.
- endTransactionOut  out  1  one-cycle end of read burst.
- busyOut  out  1  write stall request.
- busErrorOut  out  1  one-cycle error response.

Behaviour:
- Reset, asserted asynchronously at any time including mid-burst:
  - all outputs 0, state IDLE, counters 0.
  - RAM contents are not cleared.
- Address decode at begin:
  - hit if addressDataIn[1:0]==0 and BASE_ADDR ≤ addr < BASE_ADDR+4*DEPTH.
  - word index = (addr−BASE_ADDR)>>2.
  - The index increments by one per word and wraps modulo DEPTH within the burst; no error on wrap.
- States: IDLE, WRITE, RD_FETCH, READ, RD_END, ERROR.
- IDLE:
  - On beginTransactionIn, latch index, remaining = burstSizeIn and direction.
  - Miss → ERROR. Hit and write → WRITE. Hit and read → RD_FETCH.
  - beginTransactionIn in any state other than IDLE is ignored.
- ERROR:
  - busErrorOut=1 for exactly one cycle, then IDLE.
  - Write data arriving afterwards is ignored until the next begin.
- WRITE:
  - A word is accepted when dataValidIn=1 and busyOut=0. Accepting writes RAM[index] lanes where byteEnablesIn=1, index++.
  - After burstSizeIn+1 accepted words, further dataValidIn is ignored.
  - endTransactionIn → IDLE the next cycle, early or not. An early end leaves the remaining words unwritten.
  - When BUSY_EVERY=N>0: busyOut=1 for the one cycle after every Nth accepted word.
  - A word presented while busyOut=1 is not accepted; the master holds it.
- Read timing:
  - Begin at cycle T.
  - T+1 RD_FETCH issues the RAM read (RAM has a 1-cycle synchronous read).
  - From T+2, READ has dataValidOut=1 with one word per cycle, burstSizeIn+1 words back to back.
  - The cycle after the last word, RD_END: endTransactionOut=1, dataValidOut=0, addressDataOut=0, then IDLE.
- endTransactionIn during RD_FETCH/READ aborts: all outputs 0 the next cycle, IDLE.
- Simultaneous endTransactionIn and a final write word in the same cycle: the word is accepted, then IDLE.
- Reads return all 32 bits; byteEnablesIn is ignored for reads.
- burstSizeIn=0 is a single-word transaction.
- Maximum burst is 256 words.

Decomposition:
- Package ram_bus_slave_pkg holds:
  - the state enum;
  - word/byte width constants (32, 4);
  - the burst counter width (8).
- Sub-module ram_bus_slave_ram:
  - DEPTH×32 single-port synchronous RAM;
  - 4 byte-write enables;
  - registered read data.

Test Plan:
- Write burst: begin addr 32'h4000, burstSize 3, BE 4'hF, data 11,22,33,44 → no busyOut, no busErrorOut. Read burst at 32'h4000, size 3 → dataValidOut at T+2..T+5 with 11,22,33,44; endTransactionOut at T+6.
- Byte enables: write 32'hAABBCCDD then 32'h11223344 with BE 4'b0101 to 32'h4010 → read returns 32'hAA22CC44.
- Errors: begin addr 32'h3FFC, 32'h5000 and 32'h4002 → busErrorOut=1 exactly at T+1, dataValidOut stays 0, back to IDLE.
- Busy: BUSY_EVERY=2, write 4 words at 32'h4020 → busyOut high after words 2 and 4. The master holds the word and it is written once. Readback is correct.
- Wrap: write 2 words at 32'h4FFC (last index) → second word lands at index 0. A read at 32'h4000 returns it.
- Abort and reset: assert endTransactionIn at T+3 of an 8-word read → outputs 0 at T+4. Assert reset at T+3 of another read → outputs 0 immediately. After reset, the next read returns intact RAM data.

Source files
------------

// File: rtl/ram_bus_slave_pkg.sv
// Shared widths and FSM state encoding for the ram_bus_slave burst-bus target.
package ram_bus_slave_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;
  localparam int BURST_W    = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WRITE    = 3'd1;
  localparam state_t ST_RD_FETCH = 3'd2;
  localparam state_t ST_READ     = 3'd3;
  localparam state_t ST_RD_END   = 3'd4;
  localparam state_t ST_ERROR    = 3'd5;

endpackage

// File: rtl/ram_bus_slave_ram.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered read port.
module ram_bus_slave_ram
  import ram_bus_slave_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [BYTE_LANES-1:0] i_be,
  input  logic [ADDR_BITS-1:0]  i_addr,
  input  logic [WORD_W-1:0]     i_wdata,
  output logic [WORD_W-1:0]     o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // NOTE: the array is deliberately left out of reset so it maps onto a RAM macro
  // and keeps its contents across a bus reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BYTE_LANES; b++) begin
        if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_bus_slave.sv
// Burst-bus responder: decodes a word window, takes write bursts into RAM, answers read bursts.
module ram_bus_slave
  import ram_bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_4000,
  parameter int          ADDR_BITS  = 10,
  parameter int          BUSY_EVERY = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  input  logic                  readNotWriteIn,
  input  logic                  dataValidIn,
  input  logic [WORD_W-1:0]     addressDataIn,
  input  logic [BYTE_LANES-1:0] byteEnablesIn,
  input  logic [BURST_W-1:0]    burstSizeIn,
  output logic [WORD_W-1:0]     addressDataOut,
  output logic                  dataValidOut,
  output logic                  endTransactionOut,
  output logic                  busyOut,
  output logic                  busErrorOut
);

  localparam int          BUSY_CNT_W = 16;
  localparam logic [29:0] BASE_WORD  = BASE_ADDR[31:2];

  state_t                 r_state;
  logic [ADDR_BITS-1:0]   r_index;
  logic [BURST_W-1:0]     r_remaining;
  logic                   r_wdone;
  logic                   r_busy;
  logic [BUSY_CNT_W-1:0]  r_busy_cnt;

  logic [29:0]            w_word_off;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_busy_hit;
  logic [WORD_W-1:0]      w_rdata;

  // Word-granular offset; anything at or beyond DEPTH words shows up in the upper bits.
  assign w_word_off = addressDataIn[31:2] - BASE_WORD;
  assign w_hit      = (addressDataIn[1:0] == 2'b00)
                   && (addressDataIn[31:2] >= BASE_WORD)
                   && (w_word_off[29:ADDR_BITS] == '0);

  assign w_accept   = (r_state == ST_WRITE) && dataValidIn && !r_busy && !r_wdone;
  assign w_busy_hit = (BUSY_EVERY > 0) && (r_busy_cnt == BUSY_CNT_W'(BUSY_EVERY - 1));

  ram_bus_slave_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_accept),
    .i_be    (byteEnablesIn),
    .i_addr  (r_index),
    .i_wdata (addressDataIn),
    .o_rdata (w_rdata)
  );

  // NOTE: all state lives in this one non-blocking block; outputs below are pure
  // decodes of it, so every output drops to zero the instant reset asserts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_remaining <= '0;
      r_wdone     <= 1'b0;
      r_busy      <= 1'b0;
      r_busy_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (beginTransactionIn) begin
            r_index     <= w_word_off[ADDR_BITS-1:0];
            r_remaining <= burstSizeIn;
            r_wdone     <= 1'b0;
            r_busy      <= 1'b0;
            r_busy_cnt  <= '0;
            if (!w_hit)              r_state <= ST_ERROR;
            else if (readNotWriteIn) r_state <= ST_RD_FETCH;
            else                     r_state <= ST_WRITE;
          end
        end

        ST_ERROR: r_state <= ST_IDLE;

        ST_WRITE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_index <= r_index + 1'b1;
            if (r_remaining == '0) r_wdone <= 1'b1;
            else                   r_remaining <= r_remaining - 1'b1;
            if (w_busy_hit) begin
              r_busy     <= 1'b1;
              r_busy_cnt <= '0;
            end else begin
              r_busy_cnt <= r_busy_cnt + 1'b1;
            end
          end
          if (endTransactionIn) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        ST_RD_FETCH: begin
          if (endTransactionIn) begin
            r_state <= ST_IDLE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= ST_READ;
          end
        end

        ST_READ: begin
          if (endTransactionIn) begin
            r_state <= ST_IDLE;
          end else if (r_remaining == '0) begin
            r_state <= ST_RD_END;
          end else begin
            r_remaining <= r_remaining - 1'b1;
            r_index     <= r_index + 1'b1;
          end
        end

        ST_RD_END: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dataValidOut      = (r_state == ST_READ);
  assign addressDataOut    = dataValidOut ? w_rdata : '0;
  assign endTransactionOut = (r_state == ST_RD_END);
  assign busErrorOut       = (r_state == ST_ERROR);
  assign busyOut           = r_busy && (r_state == ST_WRITE);

endmodule

// File: tb/tb_ram_bus_slave.sv
// Directed and random bus transactions against a word-array model of the slave RAM.
module tb_ram_bus_slave;

  localparam int          ADDR_BITS = 10;
  localparam int          DEPTH     = 1 << ADDR_BITS;
  localparam logic [31:0] BASE      = 32'h0000_4000;
  localparam int          BUSY_N    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        bt, et, rnw, dvi;
  logic [31:0] adi;
  logic [3:0]  bei;
  logic [7:0]  bsi;
  bit          sel;

  logic [31:0] ado0, ado1, o_ad;
  logic        dvo0, dvo1, eto0, eto1, bzo0, bzo1, beo0, beo1;
  logic        o_dv, o_et, o_bz, o_be;

  int total = 0;
  int bad   = 0;

  logic [31:0] m0 [DEPTH];
  logic [31:0] m1 [DEPTH];
  logic [31:0] wq [$];
  logic [3:0]  beq [$];

  int          r_idx, r_len, r_nsend;
  logic [31:0] r_addr;

  always #5 clock = ~clock;

  ram_bus_slave #(.BASE_ADDR(BASE), .ADDR_BITS(ADDR_BITS), .BUSY_EVERY(0)) u_dut0 (
    .clock              (clock),
    .reset              (reset),
    .beginTransactionIn (bt && !sel),
    .endTransactionIn   (et && !sel),
    .readNotWriteIn     (rnw),
    .dataValidIn        (dvi && !sel),
    .addressDataIn      (adi),
    .byteEnablesIn      (bei),
    .burstSizeIn        (bsi),
    .addressDataOut     (ado0),
    .dataValidOut       (dvo0),
    .endTransactionOut  (eto0),
    .busyOut            (bzo0),
    .busErrorOut        (beo0)
  );

  ram_bus_slave #(.BASE_ADDR(BASE), .ADDR_BITS(ADDR_BITS), .BUSY_EVERY(BUSY_N)) u_dut1 (
    .clock              (clock),
    .reset              (reset),
    .beginTransactionIn (bt && sel),
    .endTransactionIn   (et && sel),
    .readNotWriteIn     (rnw),
    .dataValidIn        (dvi && sel),
    .addressDataIn      (adi),
    .byteEnablesIn      (bei),
    .burstSizeIn        (bsi),
    .addressDataOut     (ado1),
    .dataValidOut       (dvo1),
    .endTransactionOut  (eto1),
    .busyOut            (bzo1),
    .busErrorOut        (beo1)
  );

  always_comb begin
    o_ad = sel ? ado1 : ado0;
    o_dv = sel ? dvo1 : dvo0;
    o_et = sel ? eto1 : eto0;
    o_bz = sel ? bzo1 : bzo0;
    o_be = sel ? beo1 : beo0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic dv, input logic [31:0] data,
                            input logic eo, input logic err, input logic busy);
    check({tag, ".dv"},   o_dv, dv);
    check({tag, ".data"}, o_ad, data);
    check({tag, ".end"},  o_et, eo);
    check({tag, ".err"},  o_be, err);
    check({tag, ".busy"}, o_bz, busy);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
    if (sel) m1[idx] = merge(m1[idx], d, be);
    else     m0[idx] = merge(m0[idx], d, be);
  endtask

  function automatic logic [31:0] model_read(input int idx);
    return sel ? m1[idx] : m0[idx];
  endfunction

  function automatic int addr_to_idx(input logic [31:0] addr);
    logic [31:0] off;
    off = (addr - BASE) >> 2;
    return int'(off);
  endfunction

  // Presents the words queued in wq/beq, obeying busyOut; words beyond burst_len
  // are expected to be ignored. end_after=0 raises endTransactionIn with the last word.
  task automatic bus_write(input logic [31:0] addr, input int burst_len, input bit end_after);
    int k, guard, idx, acc;
    bit exp_busy;
    idx = addr_to_idx(addr);
    @(posedge clock); #1;
    bt = 1'b1; rnw = 1'b0; adi = addr; bsi = 8'(burst_len - 1);
    @(posedge clock); #1;
    bt = 1'b0;
    k = 0; guard = 0; acc = 0; exp_busy = 1'b0;
    while (k < wq.size() && guard < 4 * wq.size() + 8) begin
      dvi = 1'b1; adi = wq[k]; bei = beq[k];
      et  = !end_after && (k == wq.size() - 1);
      @(negedge clock);
      check("wr_busy", o_bz, exp_busy);
      check("wr_err", o_be, 1'b0);
      if (!o_bz) begin
        if (k < burst_len) begin
          model_write((idx + k) % DEPTH, wq[k], beq[k]);
          acc++;
        end
        exp_busy = sel && (k < burst_len) && (acc % BUSY_N == 0);
        k++;
      end else begin
        exp_busy = 1'b0;
      end
      @(posedge clock); #1;
      guard++;
    end
    if (k < wq.size()) begin
      total++; bad++;
      $error("FAIL wr_timeout: observed=%0d words expected=%0d words", k, wq.size());
    end
    dvi = 1'b0; adi = '0;
    if (end_after) begin
      et = 1'b1;
      @(negedge clock);
      check("wr_busy_end", o_bz, exp_busy);
      @(posedge clock); #1;
    end
    et = 1'b0;
    @(negedge clock);
    expect_out("wr_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: complete read; 1: endTransactionIn at cycle T+stop_at; 2: reset at T+stop_at.
  task automatic bus_read(input logic [31:0] addr, input int burst_len, input int mode,
                          input int stop_at);
    int idx;
    bit stopped;
    idx = addr_to_idx(addr);
    stopped = 1'b0;
    @(posedge clock); #1;
    bt = 1'b1; rnw = 1'b1; adi = addr; bsi = 8'(burst_len - 1);
    @(negedge clock);
    check("rd_T_dv", o_dv, 1'b0);
    @(posedge clock); #1;
    bt = 1'b0; adi = '0;
    for (int c = 1; c <= burst_len + 2; c++) begin
      if (mode != 0 && c == stop_at) begin
        if (mode == 1) et = 1'b1;
        else           reset = 1'b1;
      end
      @(negedge clock);
      if (stopped || (mode == 2 && c == stop_at))
        expect_out("rd_stopped", 1'b0, '0, 1'b0, 1'b0, 1'b0);
      else if (c == 1)
        expect_out("rd_fetch", 1'b0, '0, 1'b0, 1'b0, 1'b0);
      else if (c <= burst_len + 1)
        expect_out("rd_word", 1'b1, model_read((idx + c - 2) % DEPTH), 1'b0, 1'b0, 1'b0);
      else
        expect_out("rd_end", 1'b0, '0, 1'b1, 1'b0, 1'b0);
      @(posedge clock); #1;
      if (mode != 0 && c == stop_at) begin
        et = 1'b0; reset = 1'b0; stopped = 1'b1;
      end
    end
    @(negedge clock);
    expect_out("rd_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bus_error(input logic [31:0] addr);
    @(posedge clock); #1;
    bt = 1'b1; rnw = 1'($urandom_range(0, 1)); adi = addr; bsi = 8'd3;
    @(negedge clock);
    check("err_T", o_be, 1'b0);
    @(posedge clock); #1;
    bt = 1'b0; rnw = 1'b0; dvi = 1'b1; adi = 32'hDEAD_BEEF; bei = 4'hF;
    @(negedge clock);
    expect_out("err_T1", 1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    expect_out("err_T2", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    dvi = 1'b0; adi = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bt = 0; et = 0; rnw = 0; dvi = 0; adi = '0; bei = '0; bsi = '0; sel = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    expect_out("reset0", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1; #1;
    expect_out("reset1", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    sel = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Fill the whole window with four maximum-length bursts.
    for (int b = 0; b < 4; b++) begin
      wq.delete(); beq.delete();
      for (int i = 0; i < 256; i++) begin wq.push_back($urandom); beq.push_back(4'hF); end
      bus_write(BASE + 32'(b * 1024), 256, 1'b0);
    end
    bus_read(BASE + 32'h400, 256, 0, 0);

    wq = '{32'h11, 32'h22, 32'h33, 32'h44}; beq = '{4'hF, 4'hF, 4'hF, 4'hF};
    bus_write(32'h4000, 4, 1'b0);
    bus_read(32'h4000, 4, 0, 0);

    wq = '{32'hAABB_CCDD}; beq = '{4'hF};
    bus_write(32'h4010, 1, 1'b0);
    wq = '{32'h1122_3344}; beq = '{4'b0101};
    bus_write(32'h4010, 1, 1'b0);
    bus_read(32'h4010, 1, 0, 0);

    bus_error(32'h3FFC);
    bus_error(32'h5000);
    bus_error(32'h4002);

    wq = '{32'hCAFE_0001, 32'hCAFE_0002}; beq = '{4'hF, 4'hF};
    bus_write(32'h4FFC, 2, 1'b0);
    bus_read(32'h4000, 1, 0, 0);
    bus_read(32'h4FFC, 2, 0, 0);

    // Single-word burst with a surplus word; then an early end after two of four.
    wq = '{32'h5A5A_0001, 32'h5A5A_0002}; beq = '{4'hF, 4'hF};
    bus_write(32'h4030, 1, 1'b0);
    bus_read(32'h4030, 2, 0, 0);
    wq = '{32'h7777_0001, 32'h7777_0002}; beq = '{4'hF, 4'hF};
    bus_write(32'h4040, 4, 1'b0);
    bus_read(32'h4040, 4, 0, 0);

    bus_read(32'h4000, 8, 1, 3);
    bus_read(32'h4000, 8, 2, 3);
    bus_read(32'h4000, 8, 0, 0);

    sel = 1'b1;
    wq = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    beq = '{4'hF, 4'hF, 4'hF, 4'hF};
    bus_write(32'h4020, 4, 1'b1);
    bus_read(32'h4020, 4, 0, 0);
    sel = 1'b0;

    for (int n = 0; n < 40; n++) begin
      r_idx  = $urandom_range(0, DEPTH - 1);
      r_addr = BASE + 32'(r_idx * 4);
      r_len  = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 0) begin
        r_nsend = ($urandom_range(0, 3) == 0) ? $urandom_range(1, r_len) : r_len;
        wq.delete(); beq.delete();
        for (int i = 0; i < r_nsend; i++) begin
          wq.push_back($urandom); beq.push_back(4'($urandom));
        end
        bus_write(r_addr, r_len, 1'b0);
      end else begin
        bus_read(r_addr, r_len, 0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
